// File: rtl/rob_multiport.sv
// rob_multiport: reorder buffer with two-wide in-order dispatch, NUM_WB
// out-of-order completion ports and two-wide in-order retire.
//
// Ports
//   CLK, RST_N             clock, asynchronous active-low reset
//   Flush                  external flush, clears the ROB at the next edge
//   Disp_V / Disp_Data     two dispatch slots (slot 0 older, low half)
//   Disp_Index             entry indices offered to the two compacted slots
//   ROB_Stall              fewer than two free entries
//   WB_V/Index/Mispred/New_PC   completion ports (lowest port wins a clash)
//   Ret_*                  per-retire-slot qualifiers and fields (zero unless Ret_V)
//   Global_Flush           one-cycle pulse after a mispredicted retire
//   Redirect_PC            fetch target accompanying Global_Flush
//   Occupancy              live entry count
//   Retired_Count          retire counter, present only with ROB_PERF_CNT_EN
//
// Build option: define ROB_PERF_CNT_EN to include the retired-instruction
// counter; otherwise Retired_Count is tied to zero.
module rob_multiport #(
    parameter int DEPTH     = 128,
    parameter int IDX_W     = $clog2(DEPTH),
    parameter int NUM_WB    = 3,
    parameter int RRF_SIZE  = 7,
    parameter int R_CZ_SIZE = 8,
    parameter int SB_SIZE   = 5,
    parameter int ENTRY_W   = 16 + 3 + RRF_SIZE + 1 + 2 * (1 + R_CZ_SIZE) + 1 + SB_SIZE
) (
    input  logic                      CLK,
    input  logic                      RST_N,
    input  logic                      Flush,
    input  logic [1:0]                Disp_V,
    input  logic [2*ENTRY_W-1:0]      Disp_Data,
    output logic [2*IDX_W-1:0]        Disp_Index,
    output logic                      ROB_Stall,
    input  logic [NUM_WB-1:0]         WB_V,
    input  logic [NUM_WB*IDX_W-1:0]   WB_Index,
    input  logic [NUM_WB-1:0]         WB_Mispred,
    input  logic [NUM_WB*16-1:0]      WB_New_PC,
    output logic [1:0]                Ret_V,
    output logic [1:0]                Ret_RRF_WE,
    output logic [1:0]                Ret_C_V,
    output logic [1:0]                Ret_Z_V,
    output logic [1:0]                Ret_SB_V,
    output logic [2*3-1:0]            Ret_ARF_Addr,
    output logic [2*RRF_SIZE-1:0]     Ret_RRF_Addr,
    output logic [2*R_CZ_SIZE-1:0]    Ret_C_Addr,
    output logic [2*R_CZ_SIZE-1:0]    Ret_Z_Addr,
    output logic [2*SB_SIZE-1:0]      Ret_SB_Addr,
    output logic                      Global_Flush,
    output logic [15:0]               Redirect_PC,
    output logic [IDX_W:0]            Occupancy,
    output logic [31:0]               Retired_Count
);

    // The PC is not needed after dispatch, so only the low fields are stored.
    localparam int ST_W       = ENTRY_W - 16;
    localparam int SB_LSB     = 0;
    localparam int SB_V_BIT   = SB_SIZE;
    localparam int Z_LSB      = SB_V_BIT + 1;
    localparam int Z_W_BIT    = Z_LSB + R_CZ_SIZE;
    localparam int C_LSB      = Z_W_BIT + 1;
    localparam int C_W_BIT    = C_LSB + R_CZ_SIZE;
    localparam int RRF_WE_BIT = C_W_BIT + 1;
    localparam int RRF_LSB    = RRF_WE_BIT + 1;
    localparam int ARF_LSB    = RRF_LSB + RRF_SIZE;

    logic [ST_W-1:0]  payload_q [DEPTH];
    logic [ST_W-1:0]  payload_d [DEPTH];
    logic [15:0]      new_pc_q [DEPTH];
    logic [15:0]      new_pc_d [DEPTH];
    logic [DEPTH-1:0] busy_q, busy_d, done_q, done_d, mispred_q, mispred_d;
    logic [IDX_W:0]   head_q, head_d, tail_q, tail_d;
    logic             gflush_q, gflush_d;
    logic [15:0]      redirect_q, redirect_d;

    logic [IDX_W-1:0] h0, h1, t0, t1;
    logic             ret0, ret1, take_flush, disp_ok;
    logic [1:0]       ret_cnt, disp_cnt;
    logic [ST_W-1:0]  ret_ent [2];

    assign h0 = head_q[IDX_W-1:0];
    assign h1 = h0 + 1'b1;
    assign t0 = tail_q[IDX_W-1:0];
    assign t1 = t0 + 1'b1;

    assign Occupancy  = tail_q - head_q;
    assign ROB_Stall  = Occupancy > (IDX_W+1)'(DEPTH - 2);
    assign Disp_Index = {t1, t0};

    // Retire sees registered state only; an external flush suppresses it.
    assign ret0       = ~Flush & busy_q[h0] & done_q[h0];
    assign ret1       = ret0 & ~mispred_q[h0] & busy_q[h1] & done_q[h1];
    assign ret_cnt    = {1'b0, ret0} + {1'b0, ret1};
    assign take_flush = (ret0 & mispred_q[h0]) | (ret1 & mispred_q[h1]);
    assign disp_ok    = ~ROB_Stall & ~Flush & ~gflush_q & ~take_flush;
    assign disp_cnt   = {1'b0, Disp_V[0]} + {1'b0, Disp_V[1]};

    always_comb begin
        payload_d  = payload_q;
        new_pc_d   = new_pc_q;
        busy_d     = busy_q;
        done_d     = done_q;
        mispred_d  = mispred_q;
        head_d     = head_q;
        tail_d     = tail_q;
        gflush_d   = take_flush;
        redirect_d = redirect_q;

        // Highest port first so the lowest port's write lands last.
        for (int k = NUM_WB - 1; k >= 0; k--) begin
            if (WB_V[k] && busy_q[WB_Index[k*IDX_W +: IDX_W]]) begin
                done_d[WB_Index[k*IDX_W +: IDX_W]]    = 1'b1;
                mispred_d[WB_Index[k*IDX_W +: IDX_W]] = WB_Mispred[k];
                new_pc_d[WB_Index[k*IDX_W +: IDX_W]]  = WB_New_PC[k*16 +: 16];
            end
        end

        if (ret0) begin
            busy_d[h0]    = 1'b0;
            done_d[h0]    = 1'b0;
            mispred_d[h0] = 1'b0;
        end
        if (ret1) begin
            busy_d[h1]    = 1'b0;
            done_d[h1]    = 1'b0;
            mispred_d[h1] = 1'b0;
        end
        head_d = head_q + (IDX_W+1)'(ret_cnt);

        if (disp_ok) begin
            if (Disp_V[0]) begin
                payload_d[t0] = Disp_Data[ST_W-1:0];
                busy_d[t0]    = 1'b1;
                done_d[t0]    = 1'b0;
                mispred_d[t0] = 1'b0;
            end
            // A lone slot 1 is compacted down onto the tail entry.
            if (Disp_V[1]) begin
                payload_d[Disp_V[0] ? t1 : t0] = Disp_Data[ENTRY_W +: ST_W];
                busy_d[Disp_V[0] ? t1 : t0]    = 1'b1;
                done_d[Disp_V[0] ? t1 : t0]    = 1'b0;
                mispred_d[Disp_V[0] ? t1 : t0] = 1'b0;
            end
            tail_d = tail_q + (IDX_W+1)'(disp_cnt);
        end

        if (take_flush) begin
            redirect_d = (ret0 & mispred_q[h0]) ? new_pc_q[h0] : new_pc_q[h1];
        end

        if (Flush || take_flush) begin
            busy_d    = '0;
            done_d    = '0;
            mispred_d = '0;
            head_d    = '0;
            tail_d    = '0;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            busy_q     <= '0;
            done_q     <= '0;
            mispred_q  <= '0;
            head_q     <= '0;
            tail_q     <= '0;
            gflush_q   <= 1'b0;
            redirect_q <= '0;
        end else begin
            busy_q     <= busy_d;
            done_q     <= done_d;
            mispred_q  <= mispred_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            gflush_q   <= gflush_d;
            redirect_q <= redirect_d;
        end
    end

    // Payload and targets are only observed through busy/done, so no reset.
    always_ff @(posedge CLK) begin
        payload_q <= payload_d;
        new_pc_q  <= new_pc_d;
    end

    assign Global_Flush = gflush_q;
    assign Redirect_PC  = redirect_q;

    always_comb begin
        ret_ent[0] = payload_q[h0];
        ret_ent[1] = payload_q[h1];
        Ret_V      = {ret1, ret0};
        for (int s = 0; s < 2; s++) begin
            Ret_RRF_WE[s]                       = Ret_V[s] & ret_ent[s][RRF_WE_BIT];
            Ret_C_V[s]                          = Ret_V[s] & ret_ent[s][C_W_BIT];
            Ret_Z_V[s]                          = Ret_V[s] & ret_ent[s][Z_W_BIT];
            Ret_SB_V[s]                         = Ret_V[s] & ret_ent[s][SB_V_BIT];
            Ret_ARF_Addr[s*3 +: 3]              = Ret_V[s] ? ret_ent[s][ARF_LSB +: 3] : '0;
            Ret_RRF_Addr[s*RRF_SIZE +: RRF_SIZE] = Ret_V[s] ? ret_ent[s][RRF_LSB +: RRF_SIZE] : '0;
            Ret_C_Addr[s*R_CZ_SIZE +: R_CZ_SIZE] = Ret_V[s] ? ret_ent[s][C_LSB +: R_CZ_SIZE] : '0;
            Ret_Z_Addr[s*R_CZ_SIZE +: R_CZ_SIZE] = Ret_V[s] ? ret_ent[s][Z_LSB +: R_CZ_SIZE] : '0;
            Ret_SB_Addr[s*SB_SIZE +: SB_SIZE]    = Ret_V[s] ? ret_ent[s][SB_LSB +: SB_SIZE] : '0;
        end
    end

`ifdef ROB_PERF_CNT_EN
    logic [31:0] perf_cnt_q, perf_cnt_d;

    always_comb begin
        perf_cnt_d = perf_cnt_q + 32'(ret_cnt);
        if (Flush || take_flush) begin
            perf_cnt_d = '0;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            perf_cnt_q <= '0;
        end else begin
            perf_cnt_q <= perf_cnt_d;
        end
    end

    assign Retired_Count = perf_cnt_q;
`else
    assign Retired_Count = '0;
`endif

endmodule

// File: tb/tb_rob_multiport.sv
module tb_rob_multiport;

    localparam int DEPTH   = 4;
    localparam int IDX_W   = 2;
    localparam int NUM_WB  = 3;
    localparam int ENTRY_W = 51;

    logic                    CLK;
    logic                    RST_N;
    logic                    Flush;
    logic [1:0]              Disp_V;
    logic [2*ENTRY_W-1:0]    Disp_Data;
    logic [2*IDX_W-1:0]      Disp_Index;
    logic                    ROB_Stall;
    logic [NUM_WB-1:0]       WB_V;
    logic [NUM_WB*IDX_W-1:0] WB_Index;
    logic [NUM_WB-1:0]       WB_Mispred;
    logic [NUM_WB*16-1:0]    WB_New_PC;
    logic [1:0]              Ret_V, Ret_RRF_WE, Ret_C_V, Ret_Z_V, Ret_SB_V;
    logic [5:0]              Ret_ARF_Addr;
    logic [13:0]             Ret_RRF_Addr;
    logic [15:0]             Ret_C_Addr, Ret_Z_Addr;
    logic [9:0]              Ret_SB_Addr;
    logic                    Global_Flush;
    logic [15:0]             Redirect_PC;
    logic [IDX_W:0]          Occupancy;
    logic [31:0]             Retired_Count;

    rob_multiport #(.DEPTH(DEPTH)) u_dut (
        .CLK(CLK), .RST_N(RST_N), .Flush(Flush),
        .Disp_V(Disp_V), .Disp_Data(Disp_Data), .Disp_Index(Disp_Index),
        .ROB_Stall(ROB_Stall),
        .WB_V(WB_V), .WB_Index(WB_Index), .WB_Mispred(WB_Mispred), .WB_New_PC(WB_New_PC),
        .Ret_V(Ret_V), .Ret_RRF_WE(Ret_RRF_WE), .Ret_C_V(Ret_C_V), .Ret_Z_V(Ret_Z_V),
        .Ret_SB_V(Ret_SB_V), .Ret_ARF_Addr(Ret_ARF_Addr), .Ret_RRF_Addr(Ret_RRF_Addr),
        .Ret_C_Addr(Ret_C_Addr), .Ret_Z_Addr(Ret_Z_Addr), .Ret_SB_Addr(Ret_SB_Addr),
        .Global_Flush(Global_Flush), .Redirect_PC(Redirect_PC),
        .Occupancy(Occupancy), .Retired_Count(Retired_Count)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic        flush;
        logic [1:0]  dv;
        logic [15:0] pc0, pc1;
        logic [2:0]  wbv;
        logic [5:0]  wbi;    // {port2, port1, port0}
        logic [2:0]  wbm;
        logic [15:0] npc;
        logic [1:0]  e_retv;
        logic [2:0]  e_occ;
        logic        e_stall;
        logic        e_gf;
        logic [15:0] e_redir;
        logic [3:0]  e_didx;
        logic [13:0] e_rrf;
    } vec_t;

    vec_t vecs[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    // Payload: RRF tag = pc[6:0], ARF = pc[3:1], RRF_WE always set.
    function automatic logic [ENTRY_W-1:0] mk(input logic [15:0] pc);
        return {pc, pc[3:1], pc[6:0], 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 5'h00};
    endfunction

    function automatic void add(input logic fl, input logic [1:0] dv,
                                input logic [15:0] pc0, input logic [15:0] pc1,
                                input logic [2:0] wbv, input logic [5:0] wbi,
                                input logic [2:0] wbm, input logic [15:0] npc,
                                input logic [1:0] retv, input logic [2:0] occ,
                                input logic stall, input logic gf, input logic [15:0] redir,
                                input logic [3:0] didx, input logic [13:0] rrf);
        vec_t v;
        v.flush = fl; v.dv = dv; v.pc0 = pc0; v.pc1 = pc1;
        v.wbv = wbv; v.wbi = wbi; v.wbm = wbm; v.npc = npc;
        v.e_retv = retv; v.e_occ = occ; v.e_stall = stall; v.e_gf = gf;
        v.e_redir = redir; v.e_didx = didx; v.e_rrf = rrf;
        vecs.push_back(v);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    endtask

    task automatic drive(input vec_t v);
        Flush      = v.flush;
        Disp_V     = v.dv;
        Disp_Data  = {mk(v.pc1), mk(v.pc0)};
        WB_V       = v.wbv;
        WB_Index   = v.wbi;
        WB_Mispred = v.wbm;
        WB_New_PC  = {3{v.npc}};
    endtask

    task automatic idle_inputs();
        Flush = 0; Disp_V = 0; Disp_Data = '0;
        WB_V = 0; WB_Index = 0; WB_Mispred = 0; WB_New_PC = '0;
    endtask

    initial begin
        // Each row: inputs for one cycle, expected outputs seen during that cycle.
        //   fl dv    pc0    pc1    wbv     wbi        wbm     npc       retv  occ stl gf redir    didx     rrf
        add(0,2'b00,16'h0, 16'h0, 3'b000,6'b000000,3'b000,16'h0,    2'b00,0,0,0,16'h0,   4'b0100,14'h0);          // 0
        add(0,2'b11,16'h10,16'h12,3'b000,6'b000000,3'b000,16'h0,    2'b00,0,0,0,16'h0,   4'b0100,14'h0);          // 1
        add(0,2'b00,16'h0, 16'h0, 3'b011,6'b000100,3'b000,16'h0,    2'b00,2,0,0,16'h0,   4'b1110,14'h0);          // 2
        add(0,2'b00,16'h0, 16'h0, 3'b000,6'b000000,3'b000,16'h0,    2'b11,2,0,0,16'h0,   4'b1110,{7'h12,7'h10});  // 3
        add(0,2'b00,16'h0, 16'h0, 3'b000,6'b000000,3'b000,16'h0,    2'b00,0,0,0,16'h0,   4'b1110,14'h0);          // 4
        add(0,2'b11,16'h20,16'h22,3'b000,6'b000000,3'b000,16'h0,    2'b00,0,0,0,16'h0,   4'b1110,14'h0);          // 5
        add(0,2'b00,16'h0, 16'h0, 3'b001,6'b000011,3'b000,16'h0,    2'b00,2,0,0,16'h0,   4'b0100,14'h0);          // 6
        add(0,2'b00,16'h0, 16'h0, 3'b000,6'b000000,3'b000,16'h0,    2'b00,2,0,0,16'h0,   4'b0100,14'h0);          // 7
        add(0,2'b00,16'h0, 16'h0, 3'b100,6'b100000,3'b000,16'h0,    2'b00,2,0,0,16'h0,   4'b0100,14'h0);          // 8
        add(0,2'b00,16'h0, 16'h0, 3'b000,6'b000000,3'b000,16'h0,    2'b11,2,0,0,16'h0,   4'b0100,{7'h22,7'h20});  // 9
        add(0,2'b00,16'h0, 16'h0, 3'b000,6'b000000,3'b000,16'h0,    2'b00,0,0,0,16'h0,   4'b0100,14'h0);          // 10
        add(0,2'b11,16'h30,16'h32,3'b000,6'b000000,3'b000,16'h0,    2'b00,0,0,0,16'h0,   4'b0100,14'h0);          // 11
        add(0,2'b01,16'h34,16'h0, 3'b000,6'b000000,3'b000,16'h0,    2'b00,2,0,0,16'h0,   4'b1110,14'h0);          // 12
        add(0,2'b11,16'h50,16'h52,3'b000,6'b000000,3'b000,16'h0,    2'b00,3,1,0,16'h0,   4'b0011,14'h0);          // 13
        add(0,2'b00,16'h0, 16'h0, 3'b010,6'b000000,3'b000,16'h0,    2'b00,3,1,0,16'h0,   4'b0011,14'h0);          // 14
        add(0,2'b00,16'h0, 16'h0, 3'b000,6'b000000,3'b000,16'h0,    2'b01,3,1,0,16'h0,   4'b0011,{7'h00,7'h30});  // 15
        add(0,2'b10,16'h5E,16'h60,3'b000,6'b000000,3'b000,16'h0,    2'b00,2,0,0,16'h0,   4'b0011,14'h0);          // 16
        add(0,2'b00,16'h0, 16'h0, 3'b011,6'b001001,3'b000,16'h0,    2'b00,3,1,0,16'h0,   4'b0100,14'h0);          // 17
        add(0,2'b00,16'h0, 16'h0, 3'b000,6'b000000,3'b000,16'h0,    2'b11,3,1,0,16'h0,   4'b0100,{7'h34,7'h32});  // 18
        add(0,2'b11,16'h70,16'h72,3'b000,6'b000000,3'b000,16'h0,    2'b00,1,0,0,16'h0,   4'b0100,14'h0);          // 19
        add(0,2'b00,16'h0, 16'h0, 3'b011,6'b000011,3'b001,16'h0040, 2'b00,3,1,0,16'h0,   4'b1110,14'h0);          // 20
        add(0,2'b00,16'h0, 16'h0, 3'b000,6'b000000,3'b000,16'h0,    2'b01,3,1,0,16'h0,   4'b1110,{7'h00,7'h60});  // 21
        add(0,2'b11,16'h80,16'h82,3'b000,6'b000000,3'b000,16'h0,    2'b00,0,0,1,16'h0040,4'b0100,14'h0);          // 22
        add(0,2'b00,16'h0, 16'h0, 3'b000,6'b000000,3'b000,16'h0,    2'b00,0,0,0,16'h0,   4'b0100,14'h0);          // 23
        add(0,2'b11,16'h90,16'h92,3'b000,6'b000000,3'b000,16'h0,    2'b00,0,0,0,16'h0,   4'b0100,14'h0);          // 24
        add(0,2'b00,16'h0, 16'h0, 3'b111,6'b010000,3'b010,16'h0099, 2'b00,2,0,0,16'h0,   4'b1110,14'h0);          // 25
        add(0,2'b00,16'h0, 16'h0, 3'b000,6'b000000,3'b000,16'h0,    2'b11,2,0,0,16'h0,   4'b1110,{7'h12,7'h10});  // 26
        add(0,2'b00,16'h0, 16'h0, 3'b000,6'b000000,3'b000,16'h0,    2'b00,0,0,0,16'h0,   4'b1110,14'h0);          // 27
        add(0,2'b11,16'hA0,16'hA2,3'b000,6'b000000,3'b000,16'h0,    2'b00,0,0,0,16'h0,   4'b1110,14'h0);          // 28
        add(0,2'b00,16'h0, 16'h0, 3'b001,6'b000010,3'b000,16'h0,    2'b00,2,0,0,16'h0,   4'b0100,14'h0);          // 29
        add(1,2'b11,16'hC0,16'hC2,3'b000,6'b000000,3'b000,16'h0,    2'b00,2,0,0,16'h0,   4'b0100,14'h0);          // 30
        add(0,2'b00,16'h0, 16'h0, 3'b000,6'b000000,3'b000,16'h0,    2'b00,0,0,0,16'h0,   4'b0100,14'h0);          // 31
        add(0,2'b11,16'hB0,16'hB2,3'b000,6'b000000,3'b000,16'h0,    2'b00,0,0,0,16'h0,   4'b0100,14'h0);          // 32
        add(0,2'b11,16'hB4,16'hB6,3'b000,6'b000000,3'b000,16'h0,    2'b00,2,0,0,16'h0,   4'b1110,14'h0);          // 33
        add(0,2'b11,16'hD0,16'hD2,3'b001,6'b000000,3'b000,16'h0,    2'b00,4,1,0,16'h0,   4'b0100,14'h0);          // 34
        add(0,2'b11,16'hD4,16'hD6,3'b000,6'b000000,3'b000,16'h0,    2'b01,4,1,0,16'h0,   4'b0100,{7'h00,7'h30});  // 35
        add(0,2'b00,16'h0, 16'h0, 3'b001,6'b000001,3'b000,16'h0,    2'b00,3,1,0,16'h0,   4'b0100,14'h0);          // 36
        add(0,2'b00,16'h0, 16'h0, 3'b000,6'b000000,3'b000,16'h0,    2'b01,3,1,0,16'h0,   4'b0100,{7'h00,7'h32});  // 37
        add(0,2'b00,16'h0, 16'h0, 3'b000,6'b000000,3'b000,16'h0,    2'b00,2,0,0,16'h0,   4'b0100,14'h0);          // 38

        RST_N = 1'b0;
        idle_inputs();
        #12;
        chk("reset occupancy", 32'(Occupancy), 0);
        chk("reset ret_v", 32'(Ret_V), 0);
        chk("reset global_flush", 32'(Global_Flush), 0);
        chk("reset redirect_pc", 32'(Redirect_PC), 0);
        chk("reset retired_count", Retired_Count, 0);
        chk("reset ret_rrf_addr", 32'(Ret_RRF_Addr), 0);
        @(negedge CLK);
        RST_N = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge CLK);
            drive(vecs[i]);
            #1;
            chk($sformatf("r%0d ret_v", i), 32'(Ret_V), 32'(vecs[i].e_retv));
            chk($sformatf("r%0d ret_rrf_we", i), 32'(Ret_RRF_WE), 32'(vecs[i].e_retv));
            chk($sformatf("r%0d ret_rrf_addr", i), 32'(Ret_RRF_Addr), 32'(vecs[i].e_rrf));
            chk($sformatf("r%0d occupancy", i), 32'(Occupancy), 32'(vecs[i].e_occ));
            chk($sformatf("r%0d rob_stall", i), 32'(ROB_Stall), 32'(vecs[i].e_stall));
            chk($sformatf("r%0d global_flush", i), 32'(Global_Flush), 32'(vecs[i].e_gf));
            chk($sformatf("r%0d disp_index", i), 32'(Disp_Index), 32'(vecs[i].e_didx));
            if (vecs[i].e_gf) chk($sformatf("r%0d redirect_pc", i), 32'(Redirect_PC), 32'(vecs[i].e_redir));
        end

        // Two retires since the external flush of row 30.
`ifdef ROB_PERF_CNT_EN
        chk("retired_count after run", Retired_Count, 2);
`else
        chk("retired_count tied off", Retired_Count, 0);
`endif

        // Complete the head (entry 2), then reset asynchronously mid-cycle.
        @(negedge CLK);
        idle_inputs();
        WB_V = 3'b001; WB_Index = 6'b000010;
        @(negedge CLK);
        idle_inputs();
        #1;
        chk("pre-reset ret_v", 32'(Ret_V), 32'h1);
        chk("pre-reset occupancy", 32'(Occupancy), 2);
        #2;
        RST_N = 1'b0;
        #1;
        chk("async reset occupancy", 32'(Occupancy), 0);
        chk("async reset ret_v", 32'(Ret_V), 0);
        chk("async reset stall", 32'(ROB_Stall), 0);
        chk("async reset retired_count", Retired_Count, 0);
        @(negedge CLK);
        RST_N = 1'b1;
        #1;
        chk("post-reset disp_index", 32'(Disp_Index), 32'b0100);
        @(negedge CLK);
        Disp_V = 2'b11; Disp_Data = {mk(16'hE2), mk(16'hE0)};
        @(negedge CLK);
        idle_inputs();
        #1;
        chk("post-reset dispatch occupancy", 32'(Occupancy), 2);
        chk("post-reset ret_v", 32'(Ret_V), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
